// File: rtl/rs_latch_set_driver_if.sv
// Request/drive/feedback bundle between a requester (with its RS latch) and rs_latch_set_driver.
interface rs_latch_set_driver_if;
  logic req_valid;
  logic req_val;
  logic req_ready;
  logic s;
  logic r;
  logic q_fb;
  logic done;
  logic err;

  modport master (
    output req_valid, req_val, q_fb,
    input  req_ready, s, r, done, err
  );

  modport slave (
    input  req_valid, req_val, q_fb,
    output req_ready, s, r, done, err
  );
endinterface

// File: rtl/rs_latch_set_driver.sv
// Turns a one-bit level request into a non-overlapping s/r pulse, then checks the latch q.
// Optional RS_DRV_SKIP_EN: no pulse when the latch already holds the requested level.
//
// state  | meaning
// IDLE   | ready for a request, s=r=0
// PULSE  | driving s or r for PULSE_W cycles
// SETTLE | s=r=0, waiting SETTLE_W cycles before sampling q_fb
// CHECK  | done (and err on mismatch) high for one cycle, then back to IDLE
module rs_latch_set_driver #(
  parameter int CNT_W    = 4,
  parameter int PULSE_W  = 2,
  parameter int SETTLE_W = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  rs_latch_set_driver_if.slave       bus
);

  typedef enum logic [1:0] {IDLE, PULSE, SETTLE, CHECK} state_t;

  localparam logic [CNT_W-1:0] PULSE_LD  = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             tgt, tgt_nxt;
  logic             s_q, s_nxt;
  logic             r_q, r_nxt;
  logic             done_q, done_nxt;
  logic             err_q, err_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      tgt    <= 1'b0;
      s_q    <= 1'b0;
      r_q    <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      tgt    <= tgt_nxt;
      s_q    <= s_nxt;
      r_q    <= r_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
    end
  end

  // s and r default low so only PULSE can ever hold one of them, and never both.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    tgt_nxt   = tgt;
    s_nxt     = 1'b0;
    r_nxt     = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req_valid) begin
          tgt_nxt = bus.req_val;
`ifdef RS_DRV_SKIP_EN
          if (bus.req_val == bus.q_fb) begin
            state_nxt = CHECK;
            done_nxt  = 1'b1;
          end else begin
`else
          begin
`endif
            s_nxt     = bus.req_val;
            r_nxt     = ~bus.req_val;
            cnt_nxt   = PULSE_LD;
            state_nxt = PULSE;
          end
        end
      end
      PULSE: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
          s_nxt   = s_q;
          r_nxt   = r_q;
        end else begin
          cnt_nxt   = SETTLE_LD;
          state_nxt = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_ONE;
        end else begin
          state_nxt = CHECK;
          done_nxt  = 1'b1;
          err_nxt   = (bus.q_fb != tgt);
        end
      end
      CHECK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.req_ready = (state == IDLE);
  assign bus.s         = s_q;
  assign bus.r         = r_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
